// File: rtl/shift_left_seq_if.sv
// Bundle of request and result signals for the sequential left shifter.
// Ports: start/a/amount/rotate flow master->slave; result/busy/done/zero_flag/
//        carry_flag flow slave->master. Clock and reset stay outside the bundle.
interface shift_left_seq_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amount;
  logic             rotate;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             zero_flag;
  logic             carry_flag;

  // Requester side (testbench / ALU sequencer)
  modport master (
    output start, a, amount, rotate,
    input  result, busy, done, zero_flag, carry_flag
  );

  // Shifter side
  modport slave (
    input  start, a, amount, rotate,
    output result, busy, done, zero_flag, carry_flag
  );
endinterface

// File: rtl/shift_left_seq.sv
// Sequential left shifter: one bit position per clock, zero fill (or rotate when
// SHIFT_LEFT_ROTATE_EN is defined), with carry/zero flags and a one-cycle done pulse.
// Ports: clk, rst_n (async active-low), bus (shift_left_seq_if.slave) carrying
//        start/a/amount/rotate in and result/busy/done/zero_flag/carry_flag out.
// Latency amount+1 cycles from start to done; start is ignored while busy.
module shift_left_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_left_seq_if.slave    bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] result_q;
  logic [AMT_W-1:0] cnt;
  logic             carry_q;
  logic             fill;

`ifdef SHIFT_LEFT_ROTATE_EN
  logic rot_q;

  // Rotation feeds the outgoing MSB back into the LSB.
  assign fill = rot_q & result_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      rot_q <= bus.rotate;
    end
  end
`else
  // Logical shift only; the rotate request is accepted on the port but has no effect.
  logic unused_rotate;
  assign unused_rotate = bus.rotate;
  assign fill          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      result_q <= '0;
      cnt      <= '0;
      carry_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            result_q <= bus.a;
            cnt      <= bus.amount;
            carry_q  <= 1'b0;
            // A zero amount skips SHIFT entirely and completes next cycle.
            state    <= (bus.amount != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          carry_q  <= result_q[WIDTH-1];
          result_q <= {result_q[WIDTH-2:0], fill};
          // cnt is nonzero on every SHIFT edge, so the decrement never wraps.
          cnt      <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.result     = result_q;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = (result_q == '0);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);

endmodule
